// File: rtl/ncl_pkg.sv
// Shared types, dual-rail constants and digit helpers for the NCL sync bridge.
package ncl_pkg;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_DATA = 2'd1,
        TX_NULL = 2'd2
    } tx_state_t;

    typedef enum logic {
        RX_WAIT_NULL = 1'b0,
        RX_WAIT_DATA = 1'b1
    } rx_state_t;

    localparam logic [1:0] DR_NULL = 2'b00;
    localparam logic [1:0] DR_0    = 2'b01;
    localparam logic [1:0] DR_1    = 2'b10;

    function automatic logic [1:0] dr_encode(input logic b);
        return b ? DR_1 : DR_0;
    endfunction

    function automatic logic dr_is_complete(input logic [1:0] d);
        return (d == DR_0) || (d == DR_1);
    endfunction

    function automatic logic dr_is_null(input logic [1:0] d);
        return d == DR_NULL;
    endfunction

    function automatic logic dr_decode(input logic [1:0] d);
        return d[1];
    endfunction

endpackage

// File: rtl/ncl_sync.sv
// Multi-bit flop synchronizer for monotonic NCL rails; depth is clamped to at least two stages.
module ncl_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             init,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    localparam int NSTG = (STAGES < 2) ? 2 : STAGES;

    logic [WIDTH-1:0] r_sync [NSTG];

    // synchronizer shift chain, cleared by init
    always_ff @(posedge clk) begin
        if (init) begin
            for (int k = 0; k < NSTG; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= i_d;
            for (int k = 1; k < NSTG; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign o_q = r_sync[NSTG-1];

endmodule

// File: rtl/ncl_sync_bridge.sv
// Clocked valid/ready <-> dual-rail NCL adder array bridge.
// Optional stall watchdog with sticky wdog_err output is compiled in by NCL_WDOG_EN.
module ncl_sync_bridge
    import ncl_pkg::*;
#(
    parameter int W           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic           clk,
    input  logic           init,
    input  logic           op_valid,
    output logic           op_ready,
    input  logic [W-1:0]   op_a,
    input  logic [W-1:0]   op_b,
    input  logic           op_cin,
    output logic [2*W-1:0] a_dr,
    output logic [2*W-1:0] b_dr,
    output logic [1:0]     cin_dr,
    input  logic [W:0]     ab_ack,
    input  logic [2*W-1:0] sum_dr,
    input  logic [1:0]     cout_dr,
    output logic           sum_comp,
    output logic           carry_comp,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [W-1:0]   res_sum,
    output logic           res_cout,
    output logic           proto_err
`ifdef NCL_WDOG_EN
    ,
    output logic           wdog_err
`endif
);

    logic [W:0]       w_ack_sync;
    logic [2*W+1:0]   w_rx_sync;
    logic             w_ack_all;
    logic             w_ack_none;
    logic             w_rx_complete;
    logic             w_rx_null;
    logic             w_rx_bad;
    logic [W-1:0]     w_rx_sum;
    logic             w_rx_cout;
    logic [2*W-1:0]   w_a_enc;
    logic [2*W-1:0]   w_b_enc;
    logic [1:0]       w_cin_enc;

    tx_state_t        r_tx_state;
    tx_state_t        w_tx_next;
    logic             w_tx_accept;
    rx_state_t        r_rx_state;
    rx_state_t        w_rx_next;
    logic             w_capture;

    logic [2*W-1:0]   r_a_dr;
    logic [2*W-1:0]   r_b_dr;
    logic [1:0]       r_cin_dr;
    logic             r_comp;
    logic             r_res_valid;
    logic [W-1:0]     r_res_sum;
    logic             r_res_cout;
    logic             r_proto_err;

    ncl_sync #(.WIDTH(W+1), .STAGES(SYNC_STAGES)) u_sync_ack (
        .clk  (clk),
        .init (init),
        .i_d  (ab_ack),
        .o_q  (w_ack_sync)
    );

    ncl_sync #(.WIDTH(2*W+2), .STAGES(SYNC_STAGES)) u_sync_rx (
        .clk  (clk),
        .init (init),
        .i_d  ({cout_dr, sum_dr}),
        .o_q  (w_rx_sync)
    );

    // completion detection and decode of the synced buses, encode of the offered operands
    always_comb begin
        w_ack_all     = &w_ack_sync;
        w_ack_none    = ~|w_ack_sync;
        w_rx_complete = 1'b1;
        w_rx_null     = 1'b1;
        w_rx_bad      = 1'b0;
        w_rx_sum      = '0;
        w_a_enc       = '0;
        w_b_enc       = '0;
        for (int i = 0; i <= W; i++) begin
            w_rx_complete = w_rx_complete & dr_is_complete(w_rx_sync[2*i +: 2]);
            w_rx_null     = w_rx_null & dr_is_null(w_rx_sync[2*i +: 2]);
            w_rx_bad      = w_rx_bad | (&w_rx_sync[2*i +: 2]);
        end
        for (int i = 0; i < W; i++) begin
            w_rx_sum[i]        = dr_decode(w_rx_sync[2*i +: 2]);
            w_a_enc[2*i +: 2]  = dr_encode(op_a[i]);
            w_b_enc[2*i +: 2]  = dr_encode(op_b[i]);
        end
        w_rx_cout = dr_decode(w_rx_sync[2*W +: 2]);
        w_cin_enc = dr_encode(op_cin);
    end

    assign op_ready = (r_tx_state == TX_IDLE) & w_ack_none & ~init;

    // TX next state
    always_comb begin
        w_tx_next   = r_tx_state;
        w_tx_accept = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (op_valid && op_ready) begin
                    w_tx_accept = 1'b1;
                    w_tx_next   = TX_DATA;
                end else begin
                    w_tx_next   = TX_IDLE;
                end
            end
            TX_DATA: begin
                if (w_ack_all) begin
                    w_tx_next = TX_NULL;
                end else begin
                    w_tx_next = TX_DATA;
                end
            end
            TX_NULL: begin
                if (w_ack_none) begin
                    w_tx_next = TX_IDLE;
                end else begin
                    w_tx_next = TX_NULL;
                end
            end
            default: w_tx_next = TX_NULL;
        endcase
    end

    // TX state and operand rails; rails only change at wavefront boundaries
    always_ff @(posedge clk) begin
        if (init) begin
            r_tx_state <= TX_NULL;
            r_a_dr     <= '0;
            r_b_dr     <= '0;
            r_cin_dr   <= 2'b00;
        end else begin
            r_tx_state <= w_tx_next;
            if (w_tx_accept) begin
                r_a_dr   <= w_a_enc;
                r_b_dr   <= w_b_enc;
                r_cin_dr <= w_cin_enc;
            end else if ((r_tx_state == TX_DATA) && (w_tx_next == TX_NULL)) begin
                r_a_dr   <= '0;
                r_b_dr   <= '0;
                r_cin_dr <= 2'b00;
            end else begin
                r_a_dr   <= r_a_dr;
                r_b_dr   <= r_b_dr;
                r_cin_dr <= r_cin_dr;
            end
        end
    end

    // RX next state; a full, non-draining result register stalls the array
    always_comb begin
        w_rx_next = r_rx_state;
        w_capture = 1'b0;
        case (r_rx_state)
            RX_WAIT_DATA: begin
                if (w_rx_complete && (!r_res_valid || res_ready)) begin
                    w_capture = 1'b1;
                    w_rx_next = RX_WAIT_NULL;
                end else begin
                    w_rx_next = RX_WAIT_DATA;
                end
            end
            RX_WAIT_NULL: begin
                if (w_rx_null) begin
                    w_rx_next = RX_WAIT_DATA;
                end else begin
                    w_rx_next = RX_WAIT_NULL;
                end
            end
            default: w_rx_next = RX_WAIT_NULL;
        endcase
    end

    // RX state, completion output, result register and protocol error pulse
    always_ff @(posedge clk) begin
        if (init) begin
            r_rx_state  <= RX_WAIT_NULL;
            r_comp      <= 1'b1;
            r_res_valid <= 1'b0;
            r_res_sum   <= '0;
            r_res_cout  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_rx_state  <= w_rx_next;
            r_comp      <= (w_rx_next == RX_WAIT_NULL);
            r_proto_err <= w_rx_bad;
            if (w_capture) begin
                r_res_valid <= 1'b1;
                r_res_sum   <= w_rx_sum;
                r_res_cout  <= w_rx_cout;
            end else if (r_res_valid && res_ready) begin
                r_res_valid <= 1'b0;
            end else begin
                r_res_valid <= r_res_valid;
            end
        end
    end

    assign a_dr       = r_a_dr;
    assign b_dr       = r_b_dr;
    assign cin_dr     = r_cin_dr;
    assign sum_comp   = r_comp;
    assign carry_comp = r_comp;
    assign res_valid  = r_res_valid;
    assign res_sum    = r_res_sum;
    assign res_cout   = r_res_cout;
    assign proto_err  = r_proto_err;

`ifdef NCL_WDOG_EN
    localparam int               WDOG_W   = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_CYCLES);

    logic [WDOG_W-1:0] r_tx_wdog;
    logic [WDOG_W-1:0] r_rx_wdog;
    logic              r_wdog_err;

    // per-FSM stall counters, restarted on any state change, saturating at the limit
    always_ff @(posedge clk) begin
        if (init) begin
            r_tx_wdog  <= '0;
            r_rx_wdog  <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            if ((w_tx_next != r_tx_state) || (r_tx_state == TX_IDLE)) begin
                r_tx_wdog <= '0;
            end else if (r_tx_wdog != WDOG_MAX) begin
                r_tx_wdog <= r_tx_wdog + 1'b1;
            end else begin
                r_tx_wdog <= r_tx_wdog;
            end
            if ((w_rx_next != r_rx_state) ||
                ((r_rx_state == RX_WAIT_DATA) && !w_rx_complete)) begin
                r_rx_wdog <= '0;
            end else if (r_rx_wdog != WDOG_MAX) begin
                r_rx_wdog <= r_rx_wdog + 1'b1;
            end else begin
                r_rx_wdog <= r_rx_wdog;
            end
            if ((r_tx_wdog == WDOG_MAX) || (r_rx_wdog == WDOG_MAX)) begin
                r_wdog_err <= 1'b1;
            end else begin
                r_wdog_err <= r_wdog_err;
            end
        end
    end

    assign wdog_err = r_wdog_err;
`endif

endmodule

// File: tb/tb_ncl_sync_bridge.sv
// Directed self-checking bench for ncl_sync_bridge with a behavioural dual-rail adder array.
module tb_ncl_sync_bridge;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           init;
    logic           op_valid;
    logic           op_ready;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic           op_cin;
    logic [2*W-1:0] a_dr;
    logic [2*W-1:0] b_dr;
    logic [1:0]     cin_dr;
    logic [W:0]     ab_ack;
    logic [2*W-1:0] sum_dr;
    logic [1:0]     cout_dr;
    logic           sum_comp;
    logic           carry_comp;
    logic           res_valid;
    logic           res_ready;
    logic [W-1:0]   res_sum;
    logic           res_cout;
    logic           proto_err;
`ifdef NCL_WDOG_EN
    logic           wdog_err;
`endif

    // array model outputs and manual overrides
    logic           array_en;
    logic           arr_data;
    logic [W:0]     arr_ack;
    logic [2*W-1:0] arr_sum;
    logic [1:0]     arr_cout;
    logic [W:0]     man_ack;
    logic [2*W-1:0] man_sum;
    logic [1:0]     man_cout;

    int n_tests = 0;
    int n_fail  = 0;

    assign ab_ack  = array_en ? arr_ack  : man_ack;
    assign sum_dr  = array_en ? arr_sum  : man_sum;
    assign cout_dr = array_en ? arr_cout : man_cout;

    ncl_sync_bridge #(.W(W), .SYNC_STAGES(2), .WDOG_CYCLES(16)) dut (
        .clk        (clk),
        .init       (init),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_cin     (op_cin),
        .a_dr       (a_dr),
        .b_dr       (b_dr),
        .cin_dr     (cin_dr),
        .ab_ack     (ab_ack),
        .sum_dr     (sum_dr),
        .cout_dr    (cout_dr),
        .sum_comp   (sum_comp),
        .carry_comp (carry_comp),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_cout   (res_cout),
        .proto_err  (proto_err)
`ifdef NCL_WDOG_EN
        ,
        .wdog_err   (wdog_err)
`endif
    );

    always #5 clk = ~clk;

    // behavioural ripple adder array: DATA when inputs complete and DATA requested, NULL likewise
    initial begin
        arr_data = 1'b0;
        arr_ack  = '0;
        arr_sum  = '0;
        arr_cout = 2'b00;
    end

    always @(negedge clk) begin : array_model
        logic       in_data;
        logic       in_null;
        logic [W:0] s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        if (array_en) begin
            in_data = (cin_dr == 2'b01) || (cin_dr == 2'b10);
            in_null = (a_dr == '0) && (b_dr == '0) && (cin_dr == 2'b00);
            for (int i = 0; i < W; i++) begin
                in_data = in_data && (a_dr[2*i +: 2] != 2'b00) && (a_dr[2*i +: 2] != 2'b11)
                                  && (b_dr[2*i +: 2] != 2'b00) && (b_dr[2*i +: 2] != 2'b11);
                a[i] = a_dr[2*i+1];
                b[i] = b_dr[2*i+1];
            end
            if (!arr_data && in_data && !sum_comp) begin
                s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin_dr[1]};
                for (int i = 0; i < W; i++) begin
                    arr_sum[2*i +: 2] = s[i] ? 2'b10 : 2'b01;
                end
                arr_cout = s[W] ? 2'b10 : 2'b01;
                arr_ack  = '1;
                arr_data = 1'b1;
            end else if (arr_data && in_null && sum_comp) begin
                arr_sum  = '0;
                arr_cout = 2'b00;
                arr_ack  = '0;
                arr_data = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic sig_now(input int which);
        case (which)
            0:       return op_ready;
            1:       return res_valid;
            2:       return !sum_comp;
            default: return arr_data;
        endcase
    endfunction

    task automatic wait_sig(input string tag, input int which, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sig_now(which)) break;
        end
        check(tag, {31'd0, sig_now(which)}, 32'd1);
    endtask

    task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        wait_sig("wait_ready", 0, 200);
        op_a     = a;
        op_b     = b;
        op_cin   = cin;
        op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic drain();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("drain_valid", {31'd0, res_valid}, 32'd0);
    endtask

    initial begin : stim
        int pulses;
        init      = 1'b1;
        op_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_cin    = 1'b0;
        res_ready = 1'b0;
        array_en  = 1'b1;
        man_ack   = '0;
        man_sum   = '0;
        man_cout  = 2'b00;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_a_dr",   {24'd0, a_dr}, 32'h0);
        check("rst_cin_dr", {30'd0, cin_dr}, 32'h0);
        check("rst_ready",  {31'd0, op_ready}, 32'd0);
        check("rst_comp",   {30'd0, sum_comp, carry_comp}, 32'h3);
        check("rst_valid",  {31'd0, res_valid}, 32'd0);
        check("rst_proto",  {31'd0, proto_err}, 32'd0);
`ifdef NCL_WDOG_EN
        check("rst_wdog",   {31'd0, wdog_err}, 32'd0);
`endif
        init = 1'b0;

        // 9 + 7 + 0 = 16
        send_op(4'h9, 4'h7, 1'b0);
        check("t1_a_dr",   {24'd0, a_dr}, 32'h96);
        check("t1_b_dr",   {24'd0, b_dr}, 32'h6A);
        check("t1_cin_dr", {30'd0, cin_dr}, 32'h1);
        check("t1_ready",  {31'd0, op_ready}, 32'd0);
        wait_sig("t1_wait_res", 1, 100);
        check("t1_sum",  {28'd0, res_sum}, 32'h0);
        check("t1_cout", {31'd0, res_cout}, 32'd1);
        check("t1_comp_hi", {31'd0, sum_comp}, 32'd1);
        wait_sig("t1_wait_comp0", 2, 100);
        check("t1_carry_comp", {31'd0, carry_comp}, 32'd0);
        drain();

        // F + F + 1 = 31
        send_op(4'hF, 4'hF, 1'b1);
        check("t2_a_dr",   {24'd0, a_dr}, 32'hAA);
        check("t2_cin_dr", {30'd0, cin_dr}, 32'h2);
        wait_sig("t2_wait_res", 1, 100);
        check("t2_sum",   {28'd0, res_sum}, 32'hF);
        check("t2_cout",  {31'd0, res_cout}, 32'd1);
        check("t2_ready", {31'd0, op_ready}, 32'd0);
        check("t2_a_null", {24'd0, a_dr}, 32'h0);
        drain();

        // back-pressure: 2+1 held while 5+3 waits
        send_op(4'h2, 4'h1, 1'b0);
        wait_sig("t3_wait_res1", 1, 100);
        check("t3_sum1", {28'd0, res_sum}, 32'h3);
        send_op(4'h5, 4'h3, 1'b0);
        wait_sig("t3_wait_arr", 3, 100);
        repeat (10) @(negedge clk);
        check("t3_comp_hold",  {31'd0, sum_comp}, 32'd0);
        check("t3_valid_hold", {31'd0, res_valid}, 32'd1);
        check("t3_sum_hold",   {28'd0, res_sum}, 32'h3);
        check("t3_ready_hold", {31'd0, op_ready}, 32'd0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("t3_valid2", {31'd0, res_valid}, 32'd1);
        check("t3_sum2",   {28'd0, res_sum}, 32'h8);
        check("t3_cout2",  {31'd0, res_cout}, 32'd0);
        check("t3_comp2",  {31'd0, sum_comp}, 32'd1);

        // init mid-wavefront with partial ack, result register still full
        wait_sig("t4_wait_idle", 0, 200);
        array_en = 1'b0;
        send_op(4'h6, 4'h3, 1'b0);
        man_ack = 5'b00011;
        repeat (4) @(negedge clk);
        check("t4_a_pre", {24'd0, a_dr}, 32'h69);
        init = 1'b1;
        @(negedge clk);
        check("t4_a_dr",  {24'd0, a_dr}, 32'h0);
        check("t4_b_dr",  {24'd0, b_dr}, 32'h0);
        check("t4_cin",   {30'd0, cin_dr}, 32'h0);
        check("t4_comp",  {31'd0, sum_comp}, 32'd1);
        check("t4_valid", {31'd0, res_valid}, 32'd0);
        check("t4_ready", {31'd0, op_ready}, 32'd0);
        init     = 1'b0;
        man_ack  = '0;
        array_en = 1'b1;
        send_op(4'h1, 4'h1, 1'b0);
        wait_sig("t4_wait_res", 1, 100);
        check("t4_sum",  {28'd0, res_sum}, 32'h2);
        check("t4_cout", {31'd0, res_cout}, 32'd0);
        drain();

        // illegal 2'b11 on sum digit 2 for one cycle
        wait_sig("t5_wait_idle", 0, 200);
        array_en = 1'b0;
        man_sum  = 8'b0011_0000;
        @(negedge clk);
        man_sum  = '0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (proto_err) pulses++;
        end
        check("t5_proto_pulses", pulses, 32'd1);
        check("t5_no_capture",   {31'd0, res_valid}, 32'd0);
        check("t5_comp",         {31'd0, sum_comp}, 32'd0);
        array_en = 1'b1;

`ifdef NCL_WDOG_EN
        // stall in TX_DATA with ack held low
        array_en = 1'b0;
        send_op(4'h4, 4'h4, 1'b0);
        repeat (8) @(negedge clk);
        check("t6_wdog_early", {31'd0, wdog_err}, 32'd0);
        repeat (20) @(negedge clk);
        check("t6_wdog_set", {31'd0, wdog_err}, 32'd1);
        repeat (5) @(negedge clk);
        check("t6_wdog_sticky", {31'd0, wdog_err}, 32'd1);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        check("t6_wdog_clr", {31'd0, wdog_err}, 32'd0);
        array_en = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ncl_sync_bridge.md
Name: ncl_sync_bridge

Overview:
Clocked boundary bridge that feeds an N-bit dual-rail NCL ripple adder array and collects its results, for example a chain of the minterm full adders.
- Transmit side: turns synchronous valid/ready operands into DATA/NULL wavefronts and obeys the array's input completion acknowledge.
- Receive side: detects completeness of the dual-rail sum/carry wavefront, captures it into a clocked result register, and drives the array's output completion signals.
- Used as the test/integration harness between clocked logic and the NCL sandbox.

Parameters:
W, 4, operand/sum width in bits (dual-rail buses are 2*W wide)
SYNC_STAGES, 2, flops in each synchronizer on async inputs (minimum 2)
WDOG_CYCLES, 1024, stall limit for optional watchdog

Ports:
clk  in  1  clock
init  in  1  synchronous active-high reset
op_valid  in  1  operand offered
op_ready  out  1  operand accepted this cycle when op_valid & op_ready
op_a  in  W  operand A
op_b  in  W  operand B
op_cin  in  1  carry in
a_dr  out  2W  dual-rail A; bit i on [2i+1:2i], rail 2i+1 = logic 1, rail 2i = logic 0
b_dr  out  2W  dual-rail B, same encoding
cin_dr  out  2  dual-rail carry in
ab_ack  in  W+1  per-digit input completion from the array (async); the last bit is the carry-in completion
sum_dr  in  2W  dual-rail sum from the array (async)
cout_dr  in  2  dual-rail carry out (async)
sum_comp  out  1  output completion to the array, broadcast to all sum digits; 1 = request NULL, 0 = request DATA
carry_comp  out  1  output completion for carry out; always equal to sum_comp
res_valid  out  1  result register full
res_ready  in  1  result consumer ready
res_sum  out  W  captured sum
res_cout  out  1  captured carry out
proto_err  out  1  one-cycle pulse on an illegal dual-rail code (both rails high)

Behaviour:
- All async inputs (ab_ack, sum_dr, cout_dr) pass through SYNC_STAGES flop synchronizers before any use. Sampling multi-bit NCL buses this way is safe: rails are monotonic within a wavefront.
- Derived signals:
  - ack_all = all synced ab_ack bits 1.
  - ack_none = all synced ab_ack bits 0.
  - Mixed ack values mean a transition is in progress; wait.
- TX FSM, states TX_IDLE, TX_DATA, TX_NULL:
  - TX_IDLE: all operand rails 0 (NULL). op_ready = ack_none. On op_valid & op_ready, register operands, drive DATA from the next cycle, go to TX_DATA.
  - TX_DATA: hold DATA until ack_all, then drive NULL and go to TX_NULL.
  - TX_NULL: hold NULL until ack_none, then go to TX_IDLE.
  - op_ready = 0 outside TX_IDLE.
  - Operand rails come straight from flops (glitch-free) and never change within a wavefront.
- RX FSM, states RX_WAIT_NULL, RX_WAIT_DATA:
  - rx_complete = every synced sum/cout digit has exactly one rail high.
  - rx_null = every synced rail is 0.
  - RX_WAIT_DATA: comp outputs 0. When rx_complete and the result register is empty (or emptying this cycle via res_ready), capture the rail-1 values into res_sum/res_cout, set res_valid, set comp outputs to 1, go to RX_WAIT_NULL.
  - If rx_complete while the result register is full and not draining, hold in RX_WAIT_DATA with comp = 0. This back-pressures the array.
  - RX_WAIT_NULL: comp outputs 1 until rx_null, then 0 and back to RX_WAIT_DATA.
- Result register is one entry:
  - res_valid clears on res_valid & res_ready.
  - Capture and drain may occur in the same cycle; the new value wins and res_valid stays 1.
- proto_err pulses for one cycle in any cycle where a synced digit shows both rails high; FSM state is unaffected.
- Reset (init high, any cycle, including mid-wavefront):
  - Operand rails 0, op_ready 0.
  - sum_comp = carry_comp = 1, so the array flushes to NULL.
  - res_valid 0, res_sum 0, res_cout 0, proto_err 0.
  - TX goes to TX_NULL; RX goes to RX_WAIT_NULL. Normal operation resumes once the synced ack_none/rx_null are seen.
- Latency from operand accept to res_valid is set by the array delay plus 2*SYNC_STAGES+2 cycles minimum. No throughput assumption; one operation in flight on the TX side.

Optional Feature:
NCL_WDOG_EN:
- Compiled in: a counter per FSM resets on every state change and increments otherwise while not in TX_IDLE (TX) or RX_WAIT_DATA-with-nothing-pending (RX).
- On reaching WDOG_CYCLES it asserts a sticky output port wdog_err, cleared only by init.
- Compiled out: no counters and no wdog_err port; behaviour otherwise identical.

Decomposition:
- Shared package ncl_pkg holds:
  - TX and RX state enums.
  - Dual-rail constants: DR_NULL=2'b00, DR_0=2'b01, DR_1=2'b10.
  - Functions dr_encode, dr_is_complete, dr_is_null, dr_decode.
- Sub-module ncl_sync: parameterized multi-bit SYNC_STAGES synchronizer, instantiated for ab_ack and for {cout_dr, sum_dr}.

Test Plan:
- W=4, op_a=4'h9, op_b=4'h7, op_cin=0, behavioural array model → a_dr=8'h96, b_dr=8'h6A; then res_sum=4'h0, res_cout=1, and comp returns 0 after NULL.
- op_a=4'hF, op_b=4'hF, op_cin=1 → res_sum=4'hF, res_cout=1; op_ready stays 0 until the array acks NULL.
- res_ready held 0 across two operations → first result held, sum_comp stays 0 on the second complete wavefront until res_ready pulses, then the second result (5+3 → 4'h8, cout 0) is captured.
- Assert init while TX_DATA with partial ack → next cycle rails 00 everywhere, sum_comp=1, res_valid=0; a new op (1+1) completes correctly afterwards.
- Force sum_dr digit 2 to 2'b11 for one cycle → proto_err pulses exactly once (after sync delay), no capture.
- With NCL_WDOG_EN and WDOG_CYCLES=16, hold ab_ack at 0 after DATA → wdog_err sets at cycle 16 and stays set until init.
